// File: rtl/nco_mixer.sv
// nco_mixer: quadrature DDC mixer with an internal NCO and a sine LUT.
// Define NCO_MIXER_DITHER_EN to add LFSR phase dither below the LUT address.
module nco_mixer #(
  parameter int DW         = 16,
  parameter int LUT_ABITS  = 10,
  parameter int PHASE_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [DW-1:0]  data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic signed [DW-1:0]  data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  input  logic [PHASE_BITS-1:0] freq_i,
  input  logic                  freq_we_i,
  input  logic [PHASE_BITS-1:0] phase_off_i,
  input  logic                  mode_i,
  input  logic                  sync_i
);
  localparam int  N  = 1 << LUT_ABITS;
  localparam int  LB = PHASE_BITS - LUT_ABITS;
  localparam real PI = 3.14159265358979323846;
  localparam logic [PHASE_BITS-1:0] QTR =
    PHASE_BITS'(1) << (PHASE_BITS - 2);
  localparam logic signed [2*DW-1:0] RND =
    (2*DW)'(1) << (DW - 2);
  localparam logic signed [2*DW-1:0] SMAX =
    (2*DW)'((longint'(1) << (DW - 1)) - 1);
  localparam logic signed [2*DW-1:0] SMIN = -SMAX - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_I, S_MUL_I, S_OUT_I, S_MUL_Q, S_OUT_Q
  } state_t;

  state_t r_state, w_next;

  logic [PHASE_BITS-1:0]  r_acc, r_inc;
  logic                   r_pend;
  logic signed [DW-1:0]   r_x, r_lut, r_data;
  logic                   r_mode;
  logic [PHASE_BITS-1:0]  w_p, w_pc;
  logic [LUT_ABITS-1:0]   w_sin_a, w_cos_a, w_addr;
  logic [LB-1:0]          w_unused_s, w_unused_c;
  logic signed [2*DW-1:0] w_prod, w_shr;
  logic signed [DW-1:0]   w_sat;
  logic                   w_upd, w_sync;
  logic signed [DW-1:0]   w_lut [N];

  function automatic logic signed [DW-1:0] lut_val(input int a);
    real v;
    v = (2.0 ** (DW - 1) - 1.0) * $sin(2.0 * PI * a / N);
    return DW'($rtoi(v + ((v >= 0.0) ? 0.5 : -0.5)));
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_lut
    assign w_lut[g] = lut_val(g);
  end

`ifdef NCO_MIXER_DITHER_EN
  localparam int DB = (LB < 16) ? LB : 16;
  logic [15:0] r_lfsr;
  assign w_p = r_acc + phase_off_i + PHASE_BITS'(r_lfsr[DB-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_lfsr <= 16'hACE1;
    else if (w_upd)
      r_lfsr <= {r_lfsr[14:0],
                 r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
`else
  assign w_p = r_acc + phase_off_i;
`endif

  assign w_pc = w_p + QTR;
  assign {w_sin_a, w_unused_s} = w_p;
  assign {w_cos_a, w_unused_c} = w_pc;
  assign w_addr = (r_state == S_RD_I) ? w_cos_a : w_sin_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lut <= '0;
    else     r_lut <= w_lut[w_addr];
  end

  assign w_prod = r_x * r_lut;
  assign w_shr  = (w_prod + RND) >>> (DW - 1);
  assign w_sat  = (w_shr > SMAX) ? SMAX[DW-1:0] :
                  (w_shr < SMIN) ? SMIN[DW-1:0] :
                  w_shr[DW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (valid_i) w_next = S_RD_I;
      S_RD_I:  w_next = S_MUL_I;
      S_MUL_I: w_next = S_OUT_I;
      S_OUT_I: if (ready_i) w_next = r_mode ? S_IDLE : S_MUL_Q;
      S_MUL_Q: w_next = S_OUT_Q;
      S_OUT_Q: if (ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    last_o  = 1'b0;
    unique case (r_state)
      S_IDLE:  ready_o = 1'b1;
      S_OUT_I: begin
        valid_o = 1'b1;
        last_o  = r_mode;
      end
      S_OUT_Q: begin
        valid_o = 1'b1;
        last_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign data_o = r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x    <= '0;
      r_mode <= 1'b0;
      r_data <= '0;
    end else begin
      if (r_state == S_IDLE && valid_i) begin
        r_x    <= data_i;
        r_mode <= mode_i;
      end
      if (r_state == S_MUL_I || r_state == S_MUL_Q)
        r_data <= w_sat;
    end
  end

  // Phase advances only when the final beat of a sample is taken.
  assign w_upd  = ready_i & ((r_state == S_OUT_Q) |
                             ((r_state == S_OUT_I) & r_mode));
  assign w_sync = r_pend | sync_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_inc  <= '0;
      r_pend <= 1'b0;
    end else begin
      if (freq_we_i) r_inc <= freq_i;
      if (w_upd) begin
        r_acc  <= w_sync ? '0 : r_acc + r_inc;
        r_pend <= 1'b0;
      end else if (sync_i) begin
        if (r_state == S_IDLE) r_acc  <= '0;
        else                   r_pend <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_nco_mixer.sv
// tb_nco_mixer: scoreboard bench for nco_mixer with a trig reference model.
// Directed cases first, then randomized traffic with random backpressure.
module tb_nco_mixer;
  localparam int  DW = 16;
  localparam int  LA = 10;
  localparam int  PB = 32;
  localparam real PI = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] data_i;
  logic               valid_i;
  logic               ready_o;
  logic signed [15:0] data_o;
  logic               valid_o;
  logic               ready_i;
  logic               last_o;
  logic [31:0]        freq_i;
  logic               freq_we_i;
  logic [31:0]        phase_off_i;
  logic               mode_i;
  logic               sync_i;

  logic man_rdy;
  logic rnd_rdy;
  logic rnd_bit = 1'b1;
  assign ready_i = rnd_rdy ? rnd_bit : man_rdy;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  nco_mixer #(.DW(DW), .LUT_ABITS(LA), .PHASE_BITS(PB)) dut (
    .clk(clk), .rst(rst),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .last_o(last_o),
    .freq_i(freq_i), .freq_we_i(freq_we_i),
    .phase_off_i(phase_off_i), .mode_i(mode_i), .sync_i(sync_i)
  );

  typedef struct { int d; bit l; } beat_t;
  beat_t q[$];
  beat_t e;

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference model: ideal rounded sine table and rounded, saturated mix.
  bit [31:0] m_acc, m_inc;

  function automatic int lutv(input int a);
    real v;
    v = 32767.0 * $sin(2.0 * PI * a / 1024.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic int mix(input int x, input int c);
    longint r;
    r = (longint'(x) * longint'(c) + 64'sd16384) >>> 15;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  task automatic push_sample(input int x, input bit m, input bit [31:0] off);
    bit [31:0] p;
    bit [31:0] pc;
    int c, s;
    p  = m_acc + off;
    pc = p + 32'h4000_0000;
    c  = lutv(int'(pc[31:22]));
    s  = lutv(int'(p[31:22]));
    q.push_back('{d: mix(x, c), l: m});
    if (!m) q.push_back('{d: mix(x, s), l: 1'b1});
    m_acc = m_acc + m_inc;
  endtask

  // Monitor: scoreboard pop, stall stability and I/Q latency.
  int acc_seq = 0, seen_seq = 0, acc_t0 = 0;
  bit hold = 0, qwait = 0;
  int hcyc = 0;
  logic signed [15:0] hd;
  logic hl;

  always @(negedge clk) begin
    if (rst) begin
      hold = 0;
      qwait = 0;
      seen_seq = acc_seq;
    end else begin
      if (hold) begin
        chk(valid_o === 1'b1, "stall_valid", valid_o, 1);
        chk(data_o === hd, "stall_data", data_o, hd);
        chk(last_o === hl, "stall_last", last_o, hl);
      end
      if (seen_seq != acc_seq && valid_o) begin
        chk(cyc - acc_t0 == 3, "i_latency", cyc - acc_t0, 3);
        seen_seq = acc_seq;
      end
      if (qwait && valid_o && last_o) begin
        chk(cyc - hcyc == 2, "q_latency", cyc - hcyc, 2);
        qwait = 0;
      end
      if (valid_o && ready_i) begin
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_beat", data_o, 0);
        end else begin
          e = q.pop_front();
          chk(data_o == e.d, "data", data_o, e.d);
          chk(last_o == e.l, "last", last_o, e.l);
        end
        if (!last_o) begin
          qwait = 1;
          hcyc = cyc;
        end
      end
      hold = valid_o && !ready_i;
      hd = data_o;
      hl = last_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!ready_o && n < 500) begin
      tick();
      n++;
    end
    if (!ready_o) chk(1'b0, "idle_timeout", n, 500);
  endtask

  task automatic load_freq(input bit [31:0] f);
    wait_idle();
    freq_i = f;
    freq_we_i = 1'b1;
    tick();
    freq_we_i = 1'b0;
    m_inc = f;
  endtask

  task automatic do_sync();
    wait_idle();
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    m_acc = 0;
  endtask

  task automatic send(input int x, input bit m, input bit [31:0] off,
                      output int t0);
    wait_idle();
    data_i = 16'(x);
    mode_i = m;
    phase_off_i = off;
    valid_i = 1'b1;
    t0 = cyc;
    acc_t0 = cyc;
    push_sample(x, m, off);
    tick();
    valid_i = 1'b0;
    acc_seq++;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !ready_o) && n < 1000) begin
      tick();
      n++;
    end
    chk(q.size() == 0, "drain", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ta, tb, tc, x, n;
    bit m;
    bit [31:0] off;
    rst = 1'b1;
    data_i = '0;
    valid_i = 1'b0;
    freq_i = '0;
    freq_we_i = 1'b0;
    phase_off_i = '0;
    mode_i = 1'b0;
    sync_i = 1'b0;
    man_rdy = 1'b1;
    rnd_rdy = 1'b0;
    m_acc = 0;
    m_inc = 0;
    repeat (3) tick();
    chk(data_o == 0, "rst_data", data_o, 0);
    chk(valid_o == 0, "rst_valid", valid_o, 0);
    chk(last_o == 0, "rst_last", last_o, 0);
    chk(ready_o == 1, "rst_ready", ready_o, 1);
    rst = 1'b0;
    tick();

    // Quarter-turn increment, complex mode.
    load_freq(32'h4000_0000);
    send(16384, 1'b0, 32'h0, ta);
    send(16384, 1'b0, 32'h0, tb);
    chk(tb - ta == 6, "complex_period", tb - ta, 6);

    // Most negative input at phase 0.
    do_sync();
    send(-32768, 1'b0, 32'h0, ta);

    // Backpressure held during the I beat.
    wait_idle();
    man_rdy = 1'b0;
    send(12345, 1'b0, 32'h1234_5678, ta);
    n = 0;
    while (!valid_o && n < 10) begin
      tick();
      n++;
    end
    chk(valid_o == 1, "stall_reach_out", valid_o, 1);
    repeat (5) begin
      tick();
      chk(ready_o == 0, "stall_ready", ready_o, 0);
    end
    man_rdy = 1'b1;

    // Real mode, three samples.
    do_sync();
    send(16384, 1'b1, 32'h0, ta);
    send(16384, 1'b1, 32'h0, tb);
    send(16384, 1'b1, 32'h0, tc);
    chk(tb - ta == 4, "real_period_1", tb - ta, 4);
    chk(tc - tb == 4, "real_period_2", tc - tb, 4);

    // Sync and frequency load on the Q handshake of sample 2.
    do_sync();
    send(1000, 1'b0, 32'h0, ta);
    send(2000, 1'b0, 32'h0, ta);
    n = 0;
    while (!(valid_o && last_o) && n < 20) begin
      tick();
      n++;
    end
    chk(valid_o && last_o, "reach_out_q", valid_o, 1);
    sync_i = 1'b1;
    freq_we_i = 1'b1;
    freq_i = 32'h8000_0000;
    tick();
    sync_i = 1'b0;
    freq_we_i = 1'b0;
    m_acc = 0;
    m_inc = 32'h8000_0000;
    send(3000, 1'b0, 32'h0, ta);
    send(4000, 1'b0, 32'h0, ta);

    // Reset while the datapath is in MUL_I.
    load_freq(32'h4000_0000);
    do_sync();
    send(7000, 1'b1, 32'h0, ta);
    send(5000, 1'b0, 32'h0, ta);
    tick();
    rst = 1'b1;
    #1;
    chk(data_o == 0, "midrst_data", data_o, 0);
    chk(valid_o == 0, "midrst_valid", valid_o, 0);
    chk(last_o == 0, "midrst_last", last_o, 0);
    chk(ready_o == 1, "midrst_ready", ready_o, 1);
    q.delete();
    m_acc = 0;
    m_inc = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    load_freq(32'h4000_0000);
    send(9000, 1'b0, 32'h0, ta);
    drain();

    // Randomized traffic with random backpressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 7);
      if (n == 0) load_freq($urandom());
      if (n == 1) do_sync();
      x = (n == 2) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
      m = $urandom_range(0, 1);
      off = $urandom();
      send(x, m, off, ta);
    end
    drain();
    rnd_rdy = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/nco_mixer.md
# nco_mixer

Runtime-programmable quadrature digital down-conversion mixer with an internal NCO. It multiplies each real input sample by cos and sin of a phase accumulator and emits an interleaved I/Q stream, or an I-only stream in real mode. It sits between the ADC sample front end and the decimation filters. Frequency, phase offset and mode are configured at runtime, so the carrier can change without re-synthesis. Full ready/valid handshaking is provided on both sides.

## Interface
- DW, 16: sample and output width, signed two's complement
- LUT_ABITS, 10: address width of the full-wave sine LUT (2^LUT_ABITS entries)
- PHASE_BITS, 32: phase accumulator width; must be at least LUT_ABITS + 2

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- data_i  in  DW  signed input sample
- valid_i  in  1  input sample valid
- ready_o  out  1  input accepted when valid_i & ready_o at a rising edge
- data_o  out  DW  signed mixed output
- valid_o  out  1  output valid
- ready_i  in  1  downstream ready
- last_o  out  1  marks the final beat of a sample (Q beat in complex mode, I beat in real mode)
- freq_i  in  PHASE_BITS  phase increment per input sample
- freq_we_i  in  1  loads freq_i into the increment register
- phase_off_i  in  PHASE_BITS  static phase offset added to the LUT address path
- mode_i  in  1  0 = complex (I then Q), 1 = real (I only); sampled on input acceptance
- sync_i  in  1  phase accumulator clear request

## Operation
- **LUT.** Internal full-wave sine LUT with a 1-cycle registered read.
  - Entry a = round((2^(DW-1)-1)·sin(2πa/2^LUT_ABITS)), so values are symmetric and -2^(DW-1) never occurs.
- **Address.** p = phase_acc + phase_off_i (mod 2^PHASE_BITS); the address is the top LUT_ABITS bits of p.
  - For the cos address, add 2^(PHASE_BITS-2) to p first.
- **Output values.** I = x·cos, Q = x·sin.
  - Product is 2·DW bits.
  - Result is (prod + 2^(DW-2)) >>> (DW-1), then saturated to DW bits.
- **States:**
  - IDLE: ready_o=1. On valid_i, latch data_i and mode_i, then go to RD_I.
  - RD_I: present the cos address, then go to MUL_I.
  - MUL_I: data_o ← I, then go to OUT_I.
  - OUT_I: valid_o=1; last_o=mode.
    - The sin address is presented continuously.
    - On ready_i: in real mode, update the phase and go to IDLE; in complex mode, go to MUL_Q.
  - MUL_Q: data_o ← Q, then go to OUT_Q.
  - OUT_Q: valid_o=1, last_o=1. On ready_i, update the phase and go to IDLE.
- **Output stability.** data_o, valid_o and last_o stay constant while valid_o=1 and ready_i=0.
- **Phase update.** phase_acc ← phase_acc + inc_reg, wrapping mod 2^PHASE_BITS. If sync_pending, phase_acc ← 0 instead and sync_pending clears.
- **sync_i.**
  - In IDLE with no sample in flight, phase_acc clears on the next edge.
  - Otherwise it sets sync_pending, which is applied at the end of the current sample. The in-flight sample completes with its original phase.
- **freq_we_i.**
  - inc_reg loads on the next edge.
  - If the load coincides with a phase update, the update uses the old inc_reg.
- **Runtime changes.** phase_off_i and mode_i changes never corrupt a sample in flight: mode is latched, and phase_off_i is sampled at RD_I and at the OUT_I→MUL_Q transition.
- **Reset values.** data_o=0, valid_o=0, last_o=0, ready_o=1 (state IDLE), phase_acc=0, inc_reg=0, sync_pending=0.
  - Reset mid-sample discards the sample; there is no partial output after reset deasserts.

## Timing
- Input accepted in cycle t0 → valid_o high from cycle t0+3 with I.
- Q is valid 2 cycles after the I handshake cycle.
- Minimum period with ready_i held high:
  - complex mode: 6 cycles per input sample (ready_o high 1 of 6);
  - real mode: 4 cycles per input sample.
- No combinational path from valid_i or ready_i to any output. ready_o decodes state only.

## Configuration
- NCO_MIXER_DITHER_EN defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) is seeded to 0xACE1 on reset and advances once per phase update.
  - Its low min(16, PHASE_BITS-LUT_ABITS) bits are added to p below the address bits, before truncation.
- Undefined: no LFSR; p is truncated directly. All test plan values assume undefined.

## Test plan
- Reset, freq=0x40000000 loaded, complex mode, data_i=16384 twice, ready_i=1 → (I,Q) = (16384,0) then (0,16384); last_o=1 only on Q beats; valid_o first rises 3 cycles after acceptance.
- data_i=-32768 at phase 0 → I = -32767, no wrap or overflow; Q = 0.
- ready_i held low 5 cycles during OUT_I → data_o, valid_o and last_o stable, ready_o=0; after release, Q appears 2 cycles after the I handshake.
- mode_i=1 with freq=0x40000000, three samples of 16384 → I = 16384, 0, -16384; last_o=1 on every beat; 4-cycle period.
- sync_i pulsed during OUT_Q of sample 2, and freq_we_i=1 with freq_i=0x80000000 in the same cycle as that handshake → sample 2 uses its original phase, sample 3 uses phase 0 (I = data); sample 4 reflects increment 0x80000000.
- rst asserted in MUL_I → outputs return to reset values immediately; the next accepted sample uses phase 0.
